fc_sgd_update_engine: RTL and testbench
=======================================

Name: fc_sgd_update_engine

Overview:
- Parametrised successor to the fixed 2-lane fc2 weight-update path.
- After backprop, walks a fully connected layer's weight memory and weight-gradient memory: W <- sat(W - (G >>> lrate_shifts)) on all lanes.
- One word per cycle at full throughput, with optional in-pass gradient clear and a saturation counter.
- Sits between the layer's weight/gradient BRAMs and the training controller; one instance per FC layer.

Parameters:
- N_LANES, 2, weights per memory word (kernel count).
- PREC, 16, signed fixed-point width per lane.
- DEPTH, 640, words per memory; addresses 0..DEPTH-1.
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= DEPTH.
- RD_LAT, 1, BRAM read latency in cycles (1 or 2).
- SHIFT_W, 5, width of lrate_shifts.
- SATCNT_W, 16, saturation counter width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a pass
- lrate_shifts  input  SHIFT_W  learning-rate right shift, sampled at start
- clear_grad  input  1  zero gradient words during the pass, sampled at start
- busy  output  1  pass in progress
- done  output  1  one-cycle pulse at end of pass
- sat_count  output  SATCNT_W  lane saturations in the last pass
- w_raddr  output  ADDR_W  weight read address
- w_rdata  input  N_LANES*PREC  weight read data
- w_waddr  output  ADDR_W  weight write address
- w_wdata  output  N_LANES*PREC  weight write data
- w_we  output  1  weight write strobe
- g_raddr  output  ADDR_W  gradient read address (equal to w_raddr)
- g_rdata  input  N_LANES*PREC  gradient read data
- g_waddr  output  ADDR_W  gradient write address
- g_we  output  1  gradient write strobe; write data is all zero

Behaviour:
- Reset (rst low, asynchronous): state IDLE; busy=0, done=0, w_we=0, g_we=0, sat_count=0; all addresses 0; w_wdata=0; pipeline valids cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches shift and clear_grad, clears sat_count, then goes to RUN. Outputs are unchanged when start=0.
- RUN: issue address a=0,1,...,DEPTH-1 on consecutive cycles. After a=DEPTH-1 is issued, go to DRAIN.
- DRAIN: wait until the last write has issued, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- busy is 1 in RUN, DRAIN and DONE; 0 in IDLE.
- start is ignored unless the state is IDLE.
- Timing: start sampled at edge k. Address a is issued in cycle k+1+a. The write for address a (w_we=1, w_waddr=a) occurs in cycle k+1+a+RD_LAT+1. done is asserted in cycle k+DEPTH+RD_LAT+2.
- Read data is registered once before the write stage. The valid and address shift register depth is RD_LAT+1.
- Arithmetic, per lane:
  - sh = min(shift, PREC-1).
  - gs = G >>> sh (arithmetic shift, sign-extended).
  - d = W - gs, computed signed in PREC+1 bits.
  - d[PREC:PREC-1]=01 -> MAX = 0x7F..F; d[PREC:PREC-1]=10 -> MIN = 0x80..0; otherwise d[PREC-1:0].
- Saturation counter: increments by the number of lanes saturating in each write cycle. Stops at all-ones. Cleared on start, held after done.
- Gradient clear: if clear_grad was latched, g_we pulses with w_we and g_waddr=w_waddr; otherwise g_we=0. The gradient read of a word always completes before its clear write, so no read-after-write hazard exists.
- Address boundaries:
  - Addresses never exceed DEPTH-1 and never wrap within a pass.
  - w_raddr returns to 0 when idle.
- Reset mid-pass: the pass aborts immediately with no further writes and no done pulse. Memory contents are partially updated; the controller must restart.
- start asserted in the same cycle as done is ignored (state is DONE, not IDLE).

Test Plan:
- Basic update: PREC=16, N_LANES=2, DEPTH=8, RD_LAT=1; lane0 W=0x0100, G=0x0800, shift=8 -> written 0x00F8. Lane1 W=0x0000, G=0xFF00, shift=4 -> written 0x0010. sat_count=0.
- Timing: start at cycle 0 -> w_we high exactly in cycles 3..10 with w_waddr 0..7; done only in cycle 11; busy high in cycles 1..11.
- Saturation: W=0x7FF0, G=0x8000, shift=0 -> 0x7FFF. W=0x8010, G=0x7FFF, shift=0 -> 0x8000. sat_count=2 for a single word containing both lanes.
- Shift clamp and clear: shift=31 with G=0xFFFF -> gs=-1 and W increments by 1. With clear_grad=1 all gradient words read 0 after done; with clear_grad=0 they are unchanged.
- Handshake: start pulsed during RUN and in the DONE cycle -> ignored, exactly 8 writes. Back-to-back start in the cycle after done -> second pass begins, sat_count reset.
- Reset: rst low in cycle 5 -> w_we, busy and done go to 0 immediately. Words 0..2 are updated and 3..7 untouched; no done pulse occurs.

Source files
------------

// File: rtl/fc_sgd_update_engine_if.sv
// fc_sgd_update_engine_if
//   Bundles the control handshake (start/busy/done and pass options) and the
//   weight/gradient memory ports of one FC-layer SGD update engine.
//   master : the update engine (drives addresses, write strobes, status)
//   slave  : controller + memories (drive start, options and read data)
//   Signals:
//     start, lrate_shifts, clear_grad        pass request and options
//     busy, done, sat_count                   pass status
//     w_raddr/w_rdata, w_waddr/w_wdata/w_we   weight memory ports
//     g_raddr/g_rdata, g_waddr/g_we           gradient memory ports (clear writes zero)
interface fc_sgd_update_engine_if #(
    parameter int N_LANES  = 2,
    parameter int PREC     = 16,
    parameter int ADDR_W   = 10,
    parameter int SHIFT_W  = 5,
    parameter int SATCNT_W = 16
);
    logic                      start;
    logic [SHIFT_W-1:0]        lrate_shifts;
    logic                      clear_grad;
    logic                      busy;
    logic                      done;
    logic [SATCNT_W-1:0]       sat_count;
    logic [ADDR_W-1:0]         w_raddr;
    logic [N_LANES*PREC-1:0]   w_rdata;
    logic [ADDR_W-1:0]         w_waddr;
    logic [N_LANES*PREC-1:0]   w_wdata;
    logic                      w_we;
    logic [ADDR_W-1:0]         g_raddr;
    logic [N_LANES*PREC-1:0]   g_rdata;
    logic [ADDR_W-1:0]         g_waddr;
    logic                      g_we;

    modport master (
        input  start, lrate_shifts, clear_grad, w_rdata, g_rdata,
        output busy, done, sat_count, w_raddr, w_waddr, w_wdata, w_we,
               g_raddr, g_waddr, g_we
    );

    modport slave (
        output start, lrate_shifts, clear_grad, w_rdata, g_rdata,
        input  busy, done, sat_count, w_raddr, w_waddr, w_wdata, w_we,
               g_raddr, g_waddr, g_we
    );
endinterface

// File: rtl/fc_sgd_update_engine.sv
// fc_sgd_update_engine
//   Walks a fully connected layer's weight and weight-gradient memories once
//   per pass, one word per cycle, writing W <- sat(W - (G >>> shift)) on every
//   lane. Optionally zeroes each gradient word as it is consumed and counts
//   lane saturations over the pass.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-low reset
//     bus  : fc_sgd_update_engine_if.master (control handshake + memory ports)
module fc_sgd_update_engine #(
    parameter int N_LANES  = 2,
    parameter int PREC     = 16,
    parameter int DEPTH    = 640,
    parameter int ADDR_W   = 10,
    parameter int RD_LAT   = 1,
    parameter int SHIFT_W  = 5,
    parameter int SATCNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fc_sgd_update_engine_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                    state_reg, state_next;
    logic [ADDR_W-1:0]         raddr_reg, raddr_next;
    logic                      issue;
    logic                      load;
    logic [SHIFT_W-1:0]        shift_reg;
    logic                      clear_reg;
    // Stage i holds the word issued i+1 cycles ago; stage RD_LAT-1 sees the
    // memory data, stage RD_LAT is the write cycle.
    logic [RD_LAT:0]               vld_sr_reg;
    logic [RD_LAT:0][ADDR_W-1:0]   addr_sr_reg;
    logic [N_LANES*PREC-1:0]   wdata_reg;
    logic [SATCNT_W-1:0]       sat_count_reg;

    logic [31:0]               sh_eff;
    logic [N_LANES*PREC-1:0]   upd_word;
    logic [N_LANES-1:0]        lane_sat;
    logic [SATCNT_W-1:0]       sat_inc;
    logic [SATCNT_W:0]         sat_sum;
    logic [SATCNT_W-1:0]       sat_next;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            raddr_reg <= '0;
        end else begin
            state_reg <= state_next;
            raddr_reg <= raddr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        raddr_next = raddr_reg;
        issue      = 1'b0;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                raddr_next = '0;
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (raddr_reg == LAST_ADDR) begin
                    raddr_next = '0;
                    state_next = DRAIN;
                end else begin
                    raddr_next = raddr_reg + 1'b1;
                end
            end
            DRAIN: begin
                raddr_next = '0;
                // Once only the write stage may still hold a word, the final
                // write is happening this cycle.
                if (~|vld_sr_reg[RD_LAT-1:0])
                    state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- read pipeline ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr_reg  <= '0;
            addr_sr_reg <= '0;
        end else begin
            vld_sr_reg  <= {vld_sr_reg[RD_LAT-1:0], issue};
            addr_sr_reg <= {addr_sr_reg[RD_LAT-1:0], raddr_reg};
        end
    end

    // ---------------- per-lane update ----------------
    // Shifting a PREC-bit value by PREC-1 already leaves only sign bits.
    assign sh_eff = (32'(shift_reg) > 32'(PREC - 1)) ? 32'(PREC - 1) : 32'(shift_reg);

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic signed [PREC-1:0] w_l, g_l, gs_l;
            logic        [PREC:0]   d_l;
            logic        [PREC-1:0] upd_l;
            logic                   sat_l;

            assign w_l  = bus.w_rdata[gi*PREC +: PREC];
            assign g_l  = bus.g_rdata[gi*PREC +: PREC];
            assign gs_l = g_l >>> sh_eff;
            assign d_l  = {w_l[PREC-1], w_l} - {gs_l[PREC-1], gs_l};

            always_comb begin
                upd_l = d_l[PREC-1:0];
                sat_l = 1'b0;
                case (d_l[PREC:PREC-1])
                    2'b01: begin
                        upd_l = {1'b0, {(PREC-1){1'b1}}};
                        sat_l = 1'b1;
                    end
                    2'b10: begin
                        upd_l = {1'b1, {(PREC-1){1'b0}}};
                        sat_l = 1'b1;
                    end
                    default: ;
                endcase
            end

            assign upd_word[gi*PREC +: PREC] = upd_l;
            assign lane_sat[gi]              = sat_l;
        end
    endgenerate

    always_comb begin
        sat_inc = '0;
        for (int i = 0; i < N_LANES; i++)
            sat_inc = sat_inc + SATCNT_W'(lane_sat[i]);
    end

    assign sat_sum  = {1'b0, sat_count_reg} + {1'b0, sat_inc};
    assign sat_next = sat_sum[SATCNT_W] ? {SATCNT_W{1'b1}} : sat_sum[SATCNT_W-1:0];

    // The updated word is registered straight off the read data, which is
    // the single register stage ahead of the write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg     <= '0;
            clear_reg     <= 1'b0;
            wdata_reg     <= '0;
            sat_count_reg <= '0;
        end else begin
            if (load) begin
                shift_reg     <= bus.lrate_shifts;
                clear_reg     <= bus.clear_grad;
                sat_count_reg <= '0;
            end
            if (vld_sr_reg[RD_LAT-1]) begin
                wdata_reg     <= upd_word;
                sat_count_reg <= sat_next;
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);
    assign bus.sat_count = sat_count_reg;
    assign bus.w_raddr   = raddr_reg;
    assign bus.g_raddr   = raddr_reg;
    assign bus.w_waddr   = addr_sr_reg[RD_LAT];
    assign bus.w_wdata   = wdata_reg;
    assign bus.w_we      = vld_sr_reg[RD_LAT];
    assign bus.g_waddr   = addr_sr_reg[RD_LAT];
    assign bus.g_we      = vld_sr_reg[RD_LAT] & clear_reg;
endmodule

// File: tb/tb_fc_sgd_update_engine.sv
// tb_fc_sgd_update_engine
//   Directed bench for fc_sgd_update_engine with DEPTH=8, 2 lanes of 16 bits,
//   RD_LAT=1. Weight/gradient memories are modelled with a registered read.
module tb_fc_sgd_update_engine;
    localparam int N_LANES  = 2;
    localparam int PREC     = 16;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 3;
    localparam int RD_LAT   = 1;
    localparam int SHIFT_W  = 5;
    localparam int SATCNT_W = 16;
    localparam int MAXC     = 30;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fc_sgd_update_engine_if #(
        .N_LANES(N_LANES), .PREC(PREC), .ADDR_W(ADDR_W),
        .SHIFT_W(SHIFT_W), .SATCNT_W(SATCNT_W)
    ) bus ();

    fc_sgd_update_engine #(
        .N_LANES(N_LANES), .PREC(PREC), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT), .SHIFT_W(SHIFT_W), .SATCNT_W(SATCNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- memory model ----------------
    logic [31:0] wmem [DEPTH];
    logic [31:0] gmem [DEPTH];
    logic [31:0] wpre [DEPTH];
    logic [31:0] gpre [DEPTH];
    logic        load_mem = 1'b0;

    always @(posedge clk) begin
        bus.w_rdata <= wmem[bus.w_raddr];
        bus.g_rdata <= gmem[bus.g_raddr];
        if (load_mem) begin
            for (int i = 0; i < DEPTH; i++) begin
                wmem[i] <= wpre[i];
                gmem[i] <= gpre[i];
            end
        end else begin
            if (bus.w_we) wmem[bus.w_waddr] <= bus.w_wdata;
            if (bus.g_we) gmem[bus.g_waddr] <= '0;
        end
    end

    // ---------------- bookkeeping ----------------
    int vectors    = 0;
    int miscompares = 0;

    logic              we_hist    [MAXC+1];
    logic              gwe_hist   [MAXC+1];
    logic [ADDR_W-1:0] waddr_hist [MAXC+1];
    logic [ADDR_W-1:0] raddr_hist [MAXC+1];
    logic              done_hist  [MAXC+1];
    logic              busy_hist  [MAXC+1];
    logic [15:0]       sat_hist   [MAXC+1];

    task automatic set_all(input logic [31:0] w, input logic [31:0] g);
        for (int i = 0; i < DEPTH; i++) begin
            wpre[i] = w;
            gpre[i] = g;
        end
    endtask

    task automatic commit_mem();
        @(negedge clk);
        load_mem = 1'b1;
        @(negedge clk);
        load_mem = 1'b0;
    endtask

    // Called at a negedge: start is raised in cycle 0, the loop samples
    // cycles 1.. at each negedge and returns at the negedge of done+1.
    task automatic run_pass(input logic [SHIFT_W-1:0] sh, input logic clr,
                            input bit strobe_run, input bit strobe_done,
                            output int nwr, output int done_cyc);
        nwr      = 0;
        done_cyc = -1;
        bus.lrate_shifts = sh;
        bus.clear_grad   = clr;
        bus.start        = 1'b1;
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (strobe_run && c == 4) begin
                bus.start        = 1'b1;
                bus.lrate_shifts = '0;
                bus.clear_grad   = ~clr;
            end
            we_hist[c]    = bus.w_we;
            gwe_hist[c]   = bus.g_we;
            waddr_hist[c] = bus.w_waddr;
            raddr_hist[c] = bus.w_raddr;
            done_hist[c]  = bus.done;
            busy_hist[c]  = bus.busy;
            sat_hist[c]   = bus.sat_count;
            if (bus.w_we) nwr++;
            if (done_cyc >= 0) break;
            if (bus.done) begin
                done_cyc = c;
                if (strobe_done) bus.start = 1'b1;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.start = 1'b0; bus.lrate_shifts = '0; bus.clear_grad = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        vectors++; if (bus.w_we !== 1'b0 || bus.g_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got w%b g%b expected 0 0", bus.w_we, bus.g_we); end
        vectors++; if (bus.sat_count !== 16'd0) begin miscompares++; $display("FAIL reset_sat: got %0d expected 0", bus.sat_count); end
        vectors++; if (bus.w_raddr !== 3'd0 || bus.w_waddr !== 3'd0 || bus.g_waddr !== 3'd0) begin miscompares++; $display("FAIL reset_addr: got r%0d w%0d g%0d expected 0 0 0", bus.w_raddr, bus.w_waddr, bus.g_waddr); end
        vectors++; if (bus.w_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata: got %h expected 0", bus.w_wdata); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
        $display("reset: state checked");
    endtask

    task automatic test_basic();
        int nwr, dc;
        // shift 8: lane0 0x0100-(0x0800>>>8)=0x00F8, lane1 0x0000-(-1)=0x0001
        set_all(32'h0000_0100, 32'hFF00_0800);
        commit_mem();
        run_pass(5'd8, 1'b0, 1'b0, 1'b0, nwr, dc);
        vectors++; if (dc != 11) begin miscompares++; $display("FAIL basic8_done: got %0d expected 11", dc); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (wmem[i] !== 32'h0001_00F8) begin miscompares++; $display("FAIL basic8_w[%0d]: got %h expected 000100f8", i, wmem[i]); end
            vectors++; if (gmem[i] !== 32'hFF00_0800) begin miscompares++; $display("FAIL basic8_g[%0d]: got %h expected ff000800", i, gmem[i]); end
        end
        vectors++; if (bus.sat_count !== 16'd0) begin miscompares++; $display("FAIL basic8_sat: got %0d expected 0", bus.sat_count); end
        $display("basic shift=8: %0d writes, done in cycle %0d", nwr, dc);
        // shift 4: lane0 0x0100-0x0080=0x0080, lane1 0x0000-0xFFF0=0x0010
        commit_mem();
        run_pass(5'd4, 1'b0, 1'b0, 1'b0, nwr, dc);
        vectors++; if (dc != 11) begin miscompares++; $display("FAIL basic4_done: got %0d expected 11", dc); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (wmem[i] !== 32'h0010_0080) begin miscompares++; $display("FAIL basic4_w[%0d]: got %h expected 00100080", i, wmem[i]); end
        end
        $display("basic shift=4: %0d writes, done in cycle %0d", nwr, dc);
    endtask

    task automatic test_timing();
        int nwr, dc;
        set_all(32'h0000_0100, 32'hFF00_0800);
        commit_mem();
        run_pass(5'd8, 1'b0, 1'b0, 1'b0, nwr, dc);
        vectors++; if (nwr != 8) begin miscompares++; $display("FAIL timing_nwr: got %0d expected 8", nwr); end
        for (int c = 1; c <= 12; c++) begin
            logic exp_we, exp_done, exp_busy;
            exp_we   = (c >= 3 && c <= 10);
            exp_done = (c == 11);
            exp_busy = (c >= 1 && c <= 11);
            vectors++;
            if (we_hist[c] !== exp_we || (exp_we && waddr_hist[c] !== 3'(c - 3))) begin
                miscompares++; $display("FAIL timing_we[c%0d]: got we=%b addr=%0d expected we=%b addr=%0d", c, we_hist[c], waddr_hist[c], exp_we, c - 3);
            end
            vectors++; if (done_hist[c] !== exp_done) begin miscompares++; $display("FAIL timing_done[c%0d]: got %b expected %b", c, done_hist[c], exp_done); end
            vectors++; if (busy_hist[c] !== exp_busy) begin miscompares++; $display("FAIL timing_busy[c%0d]: got %b expected %b", c, busy_hist[c], exp_busy); end
            vectors++;
            if (raddr_hist[c] !== ((c <= 8) ? 3'(c - 1) : 3'd0)) begin
                miscompares++; $display("FAIL timing_raddr[c%0d]: got %0d expected %0d", c, raddr_hist[c], (c <= 8) ? c - 1 : 0);
            end
        end
        $display("timing: %0d writes, done in cycle %0d", nwr, dc);
    endtask

    task automatic test_saturation();
        int nwr, dc;
        set_all(32'h0000_0000, 32'h0000_0000);
        wpre[0] = 32'h8010_7FF0; gpre[0] = 32'h7FFF_8000;   // both lanes saturate
        wpre[1] = 32'h8001_7FFE; gpre[1] = 32'h0001_FFFF;   // land exactly on the limits
        commit_mem();
        run_pass(5'd0, 1'b0, 1'b0, 1'b0, nwr, dc);
        vectors++; if (wmem[0] !== 32'h8000_7FFF) begin miscompares++; $display("FAIL sat_w0: got %h expected 80007fff", wmem[0]); end
        vectors++; if (wmem[1] !== 32'h8000_7FFF) begin miscompares++; $display("FAIL sat_w1: got %h expected 80007fff", wmem[1]); end
        vectors++; if (wmem[7] !== 32'h0000_0000) begin miscompares++; $display("FAIL sat_w7: got %h expected 00000000", wmem[7]); end
        vectors++; if (bus.sat_count !== 16'd2) begin miscompares++; $display("FAIL sat_count: got %0d expected 2", bus.sat_count); end
        vectors++; if (dc != 11) begin miscompares++; $display("FAIL sat_done: got %0d expected 11", dc); end
        $display("saturation: sat_count=%0d", bus.sat_count);
    endtask

    task automatic test_shift_clear();
        int nwr, dc;
        // shift 31 clamps to 15: 0xFFFF -> -1 (W+1), 0x7FFF -> 0 (W unchanged)
        set_all(32'h0500_1234, 32'h7FFF_FFFF);
        commit_mem();
        run_pass(5'd31, 1'b1, 1'b0, 1'b0, nwr, dc);
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (wmem[i] !== 32'h0500_1235) begin miscompares++; $display("FAIL clamp_w[%0d]: got %h expected 05001235", i, wmem[i]); end
            vectors++; if (gmem[i] !== 32'h0000_0000) begin miscompares++; $display("FAIL clear_g[%0d]: got %h expected 00000000", i, gmem[i]); end
        end
        for (int c = 1; c <= 12; c++) begin
            vectors++; if (gwe_hist[c] !== we_hist[c]) begin miscompares++; $display("FAIL clear_gwe[c%0d]: got %b expected %b", c, gwe_hist[c], we_hist[c]); end
        end
        $display("shift clamp + clear_grad=1: %0d writes", nwr);
        commit_mem();
        run_pass(5'd31, 1'b0, 1'b0, 1'b0, nwr, dc);
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (gmem[i] !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL noclear_g[%0d]: got %h expected 7fffffff", i, gmem[i]); end
        end
        for (int c = 1; c <= 12; c++) begin
            vectors++; if (gwe_hist[c] !== 1'b0) begin miscompares++; $display("FAIL noclear_gwe[c%0d]: got %b expected 0", c, gwe_hist[c]); end
        end
        $display("clear_grad=0: %0d writes", nwr);
    endtask

    task automatic test_handshake();
        int nwr, dc;
        // start pulses during RUN (with different options) and in the DONE cycle
        set_all(32'h0000_0100, 32'h0000_0800);
        commit_mem();
        run_pass(5'd8, 1'b0, 1'b1, 1'b1, nwr, dc);
        vectors++; if (nwr != 8) begin miscompares++; $display("FAIL hs_nwr: got %0d expected 8", nwr); end
        vectors++; if (dc != 11) begin miscompares++; $display("FAIL hs_done: got %0d expected 11", dc); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (wmem[i] !== 32'h0000_00F8 || gmem[i] !== 32'h0000_0800) begin miscompares++; $display("FAIL hs_mem[%0d]: got w=%h g=%h expected w=000000f8 g=00000800", i, wmem[i], gmem[i]); end
        end
        vectors++; if (busy_hist[12] !== 1'b0) begin miscompares++; $display("FAIL hs_busy_after: got %b expected 0", busy_hist[12]); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (bus.busy !== 1'b0 || bus.w_we !== 1'b0) begin miscompares++; $display("FAIL hs_idle[%0d]: got busy=%b we=%b expected 0 0", c, bus.busy, bus.w_we); end
        end
        $display("handshake: %0d writes, done in cycle %0d", nwr, dc);
    endtask

    task automatic test_back_to_back();
        int nwr, dc;
        set_all(32'h0000_7FF0, 32'h0000_8000);
        commit_mem();
        run_pass(5'd0, 1'b0, 1'b0, 1'b0, nwr, dc);
        vectors++; if (bus.sat_count !== 16'd8) begin miscompares++; $display("FAIL b2b_sat1: got %0d expected 8", bus.sat_count); end
        // Second start lands in the cycle right after done.
        run_pass(5'd0, 1'b0, 1'b0, 1'b0, nwr, dc);
        vectors++; if (busy_hist[1] !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b expected 1", busy_hist[1]); end
        vectors++; if (sat_hist[1] !== 16'd0) begin miscompares++; $display("FAIL b2b_satclr: got %0d expected 0", sat_hist[1]); end
        vectors++; if (dc != 11 || nwr != 8) begin miscompares++; $display("FAIL b2b_pass: got done=%0d writes=%0d expected 11 8", dc, nwr); end
        vectors++; if (bus.sat_count !== 16'd8) begin miscompares++; $display("FAIL b2b_sat2: got %0d expected 8", bus.sat_count); end
        vectors++; if (wmem[5] !== 32'h0000_7FFF) begin miscompares++; $display("FAIL b2b_w5: got %h expected 00007fff", wmem[5]); end
        $display("back_to_back: second pass done in cycle %0d", dc);
    endtask

    task automatic test_reset_midpass();
        int writes_after, dones_after;
        set_all(32'h0000_0100, 32'h0000_0800);
        commit_mem();
        bus.lrate_shifts = 5'd8; bus.clear_grad = 1'b0; bus.start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        vectors++; if (bus.w_we !== 1'b1 || bus.w_waddr !== 3'd2) begin miscompares++; $display("FAIL mid_prewrite: got we=%b addr=%0d expected 1 2", bus.w_we, bus.w_waddr); end
        // Reset right after the write of word 2 commits.
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        vectors++; if (bus.w_we !== 1'b0) begin miscompares++; $display("FAIL mid_we: got %b expected 0", bus.w_we); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mid_done: got %b expected 0", bus.done); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        writes_after = 0; dones_after = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.w_we) writes_after++;
            if (bus.done) dones_after++;
        end
        vectors++; if (writes_after != 0 || dones_after != 0) begin miscompares++; $display("FAIL mid_after: got writes=%0d dones=%0d expected 0 0", writes_after, dones_after); end
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] exp_w;
            exp_w = (i <= 2) ? 32'h0000_00F8 : 32'h0000_0100;
            vectors++; if (wmem[i] !== exp_w) begin miscompares++; $display("FAIL mid_w[%0d]: got %h expected %h", i, wmem[i], exp_w); end
        end
        $display("reset mid-pass: aborted after word 2");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timing();
        test_saturation();
        test_shift_clear();
        test_handshake();
        test_back_to_back();
        test_reset_midpass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
